// File: rtl/audio_pkg.sv
// Shared types, clock defaults and divider helper for the I2S headphone scheduler.
package audio_pkg;

    typedef struct packed {
        logic signed [15:0] left;
        logic signed [15:0] right;
    } stereo_sample_t;

    localparam int unsigned DEF_CLK_HZ_PAL  = 31500000;
    localparam int unsigned DEF_CLK_HZ_NTSC = 32940000;
    localparam int unsigned DEF_SAMPLE_HZ   = 24000;

    // Terminal count of the half-bit divider: 64 bit-clock half periods per sample.
    function automatic int unsigned half_div(input int unsigned clk_hz, input int unsigned fs);
        return clk_hz / (fs * 64) - 1;
    endfunction

endpackage

// File: rtl/sample_fifo2.sv
// Two-entry FIFO of stereo samples between the mixer handshake and the frame loader.
module sample_fifo2
    import audio_pkg::*;
(
    input  logic           clk,
    input  logic           pll_lock,
    input  logic           push,
    input  stereo_sample_t din,
    input  logic           pop,
    output stereo_sample_t dout,
    output logic [1:0]     count,
    output logic           full,
    output logic           empty
);

    stereo_sample_t mem [2];
    logic           wr_ptr;
    logic           rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge pll_lock) begin
        if (!pll_lock) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/i2s_audio_sched.sv
// I2S transmit scheduler: bit-clock divider, 32-bit left-justified framer,
// volume/mute/mono scaling and a two-entry sample buffer.
module i2s_audio_sched
    import audio_pkg::*;
#(
    parameter int          STEREO      = 0,
    parameter int unsigned CLK_HZ_PAL  = DEF_CLK_HZ_PAL,
    parameter int unsigned CLK_HZ_NTSC = DEF_CLK_HZ_NTSC,
    parameter int unsigned SAMPLE_HZ   = DEF_SAMPLE_HZ
)(
    input  logic               clk,
    input  logic               pll_lock,
    input  logic               ntscmode,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic signed [15:0] s_left,
    input  logic signed [15:0] s_right,
    input  logic               mute,
    input  logic [1:0]         volume,
    output logic               hp_bck,
    output logic               hp_ws,
    output logic               hp_din,
    output logic               frame_strobe,
    output logic               underrun
);

    localparam logic [7:0] HALF_PAL  = 8'(half_div(CLK_HZ_PAL, SAMPLE_HZ));
    localparam logic [7:0] HALF_NTSC = 8'(half_div(CLK_HZ_NTSC, SAMPLE_HZ));

    logic [7:0]         div_cnt;
    logic [7:0]         half_q;
    logic [4:0]         bit_cnt;
    logic signed [15:0] raw_l;
    logic signed [15:0] raw_r;
    logic [15:0]        hold_l;
    logic [15:0]        hold_r;
    logic [15:0]        word;

    logic               reload;
    logic               advance;
    logic               load;
    logic               push;
    logic               pop_eff;
    logic               s_ready_nxt;

    stereo_sample_t     fifo_in;
    stereo_sample_t     fifo_out;
    logic [1:0]         fifo_count;
    logic               fifo_full;
    logic               fifo_empty;

    logic signed [15:0] src_l;
    logic signed [15:0] src_r;
    logic signed [15:0] mix;
    logic [15:0]        nxt_l;
    logic [15:0]        nxt_r;

    function automatic logic [15:0] scale(input logic signed [15:0] x,
                                          input logic [1:0]         vol,
                                          input logic               mt);
        logic [15:0] y;
        if (mt) begin
            y = '0;
        end else begin
            case (vol)
                2'd0:    y = '0;
                2'd1:    y = x >>> 2;
                2'd2:    y = x >>> 1;
                default: y = x;
            endcase
        end
        return y;
    endfunction

    assign reload  = (div_cnt == half_q);
    assign advance = reload && hp_bck;
    assign load    = advance && (bit_cnt == 5'd31);
    assign push    = s_valid && s_ready;
    assign pop_eff = load && !fifo_empty;
    assign fifo_in = {s_left, s_right};

    sample_fifo2 u_fifo (
        .clk      (clk),
        .pll_lock (pll_lock),
        .push     (push),
        .din      (fifo_in),
        .pop      (load),
        .dout     (fifo_out),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // An empty buffer at load replays the previous raw sample.
    assign src_l = fifo_empty ? raw_l : fifo_out.left;
    assign src_r = fifo_empty ? raw_r : fifo_out.right;
    assign mix   = (src_l >>> 1) + (src_r >>> 1);

    always_comb begin
        nxt_l = '0;
        nxt_r = '0;
        if (STEREO != 0) begin
            nxt_l = scale(src_l, volume, mute);
            nxt_r = scale(src_r, volume, mute);
        end else begin
            nxt_l = scale(mix, volume, mute);
            nxt_r = nxt_l;
        end
    end

    // Ready reflects the occupancy after this cycle's push/pop, so a full buffer never sees a push.
    always_comb begin
        s_ready_nxt = 1'b0;
        if (pop_eff) begin
            s_ready_nxt = 1'b1;
        end else if (push) begin
            s_ready_nxt = (fifo_count == 2'd0);
        end else begin
            s_ready_nxt = !fifo_full;
        end
    end

    always_ff @(posedge clk or negedge pll_lock) begin
        if (!pll_lock) begin
            div_cnt      <= '0;
            half_q       <= HALF_PAL;
            hp_bck       <= 1'b0;
            bit_cnt      <= '0;
            raw_l        <= '0;
            raw_r        <= '0;
            hold_l       <= '0;
            hold_r       <= '0;
            s_ready      <= 1'b0;
            frame_strobe <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            frame_strobe <= 1'b0;
            underrun     <= 1'b0;
            s_ready      <= s_ready_nxt;
            // Mode is captured right after each reload so a count never changes length midway.
            if (div_cnt == 8'd0) begin
                half_q <= ntscmode ? HALF_NTSC : HALF_PAL;
            end
            if (reload) begin
                div_cnt <= '0;
                hp_bck  <= ~hp_bck;
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end
            if (advance) begin
                bit_cnt <= bit_cnt + 5'd1;
                if (load) begin
                    raw_l        <= src_l;
                    raw_r        <= src_r;
                    hold_l       <= nxt_l;
                    hold_r       <= nxt_r;
                    frame_strobe <= 1'b1;
                    underrun     <= fifo_empty;
                end
            end
        end
    end

    assign word   = bit_cnt[4] ? hold_r : hold_l;
    assign hp_ws  = bit_cnt[4];
    assign hp_din = word[4'd15 - bit_cnt[3:0]];

endmodule

// File: tb/tb_i2s_audio_sched.sv
// Bench for i2s_audio_sched: stereo and mono instances share stimulus and are
// checked each cycle against a cycle-count based frame model plus literal expectations.
module tb_i2s_audio_sched;

    logic        clk = 1'b0;
    logic        pll_lock = 1'b0;
    logic        ntscmode = 1'b0;
    logic        s_valid = 1'b0;
    logic [15:0] s_left = '0;
    logic [15:0] s_right = '0;
    logic        mute = 1'b0;
    logic [1:0]  volume = 2'd3;

    logic s_ready_st, hp_bck_st, hp_ws_st, hp_din_st, frame_strobe_st, underrun_st;
    logic s_ready_mo, hp_bck_mo, hp_ws_mo, hp_din_mo, frame_strobe_mo, underrun_mo;

    i2s_audio_sched #(.STEREO(1)) u_st (
        .clk(clk), .pll_lock(pll_lock), .ntscmode(ntscmode),
        .s_valid(s_valid), .s_ready(s_ready_st), .s_left(s_left), .s_right(s_right),
        .mute(mute), .volume(volume), .hp_bck(hp_bck_st), .hp_ws(hp_ws_st),
        .hp_din(hp_din_st), .frame_strobe(frame_strobe_st), .underrun(underrun_st)
    );

    i2s_audio_sched #(.STEREO(0)) u_mo (
        .clk(clk), .pll_lock(pll_lock), .ntscmode(ntscmode),
        .s_valid(s_valid), .s_ready(s_ready_mo), .s_left(s_left), .s_right(s_right),
        .mute(mute), .volume(volume), .hp_bck(hp_bck_mo), .hp_ws(hp_ws_mo),
        .hp_din(hp_din_mo), .frame_strobe(frame_strobe_mo), .underrun(underrun_mo)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 60)
                $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out at %0t", name, $time);
    endtask

    // Inputs as seen by the DUT at each rising edge.
    logic        lock_q = 1'b0, v_q = 1'b0, mute_q = 1'b0, ntsc_q = 1'b0;
    logic [1:0]  vol_q = '0;
    logic [15:0] l_q = '0, r_q = '0;

    always @(posedge clk) begin
        lock_q <= pll_lock;
        v_q    <= s_valid;
        mute_q <= mute;
        ntsc_q <= ntscmode;
        vol_q  <= volume;
        l_q    <= s_left;
        r_q    <= s_right;
    end

    // Model: everything follows from n, the number of clocks since reset release.
    int                 m_n = 0;
    int                 m_h = 20;
    logic [31:0]        m_q [$];
    logic [15:0]        raw_l = '0, raw_r = '0, hl = '0, hr = '0, hm = '0;
    logic signed [15:0] mix_m;
    logic               m_ready = 1'b0, m_strobe = 1'b0, m_ur = 1'b0, m_hs;
    int                 b;
    logic               e_bck, e_ws, e_din_st, e_din_mo;

    function automatic logic [15:0] scale(input logic [15:0] x, input logic [1:0] vol, input logic mt);
        logic signed [15:0] s;
        s = x;
        if (mt || vol == 2'd0) return 16'h0000;
        if (vol == 2'd1) return 16'(s >>> 2);
        if (vol == 2'd2) return 16'(s >>> 1);
        return x;
    endfunction

    always @(negedge clk) begin
        if (!pll_lock || !lock_q) begin
            m_n = 0;
            m_q.delete();
            raw_l = '0; raw_r = '0; hl = '0; hr = '0; hm = '0;
            m_ready = 1'b0; m_strobe = 1'b0; m_ur = 1'b0;
        end else begin
            m_hs = v_q && m_ready;
            m_n++;
            if (m_n == 1) m_h = ntsc_q ? 21 : 20;
            m_strobe = 1'b0;
            m_ur = 1'b0;
            if (m_n % (64 * m_h) == 0) begin
                if (m_q.size() > 0) {raw_l, raw_r} = m_q.pop_front();
                else m_ur = 1'b1;
                m_strobe = 1'b1;
                hl = scale(raw_l, vol_q, mute_q);
                hr = scale(raw_r, vol_q, mute_q);
                mix_m = ($signed(raw_l) >>> 1) + ($signed(raw_r) >>> 1);
                hm = scale(mix_m, vol_q, mute_q);
            end
            if (m_hs) m_q.push_back({l_q, r_q});
            m_ready = (m_q.size() < 2);
        end
        e_bck    = ((m_n / m_h) % 2) != 0;
        b        = (m_n / (2 * m_h)) % 32;
        e_ws     = (b >= 16);
        e_din_st = e_ws ? hr[15 - (b % 16)] : hl[15 - (b % 16)];
        e_din_mo = hm[15 - (b % 16)];
        chk("st_bck", hp_bck_st, e_bck);
        chk("st_ws", hp_ws_st, e_ws);
        chk("st_din", hp_din_st, e_din_st);
        chk("st_strobe", frame_strobe_st, m_strobe);
        chk("st_underrun", underrun_st, m_ur);
        chk("st_ready", s_ready_st, m_ready);
        chk("mo_bck", hp_bck_mo, e_bck);
        chk("mo_ws", hp_ws_mo, e_ws);
        chk("mo_din", hp_din_mo, e_din_mo);
        chk("mo_strobe", frame_strobe_mo, m_strobe);
        chk("mo_underrun", underrun_mo, m_ur);
        chk("mo_ready", s_ready_mo, m_ready);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r, output int acc_n);
        logic took;
        s_left = l;
        s_right = r;
        s_valid = 1'b1;
        acc_n = -1;
        for (int c = 0; c < 3000; c++) begin
            took = s_ready_st;
            tick();
            if (took) begin
                acc_n = m_n;
                break;
            end
        end
        if (acc_n < 0) timeout("push");
    endtask

    task automatic wait_strobe(output int at_n, output logic ur);
        at_n = -1;
        ur = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            tick();
            if (frame_strobe_st) begin
                at_n = m_n;
                ur = underrun_st;
                break;
            end
        end
        if (at_n < 0) timeout("frame_strobe");
    endtask

    task automatic capture(output logic [31:0] st, output logic [31:0] mo, output int period);
        logic prev;
        int   k, t0;
        prev = hp_bck_st;
        k = 0;
        t0 = 0;
        period = 0;
        st = '0;
        mo = '0;
        for (int c = 0; c < 1500 && k < 32; c++) begin
            tick();
            if (!prev && hp_bck_st) begin
                st = {st[30:0], hp_din_st};
                mo = {mo[30:0], hp_din_mo};
                if (k == 0) t0 = m_n;
                if (k == 1) period = m_n - t0;
                k++;
            end
            prev = hp_bck_st;
        end
        if (k < 32) timeout("capture");
    endtask

    task automatic release_and_time_rise(input int exp_rise);
        int c;
        pll_lock = 1'b1;
        c = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            c++;
            if (c == 1) chk("ready_after_release", s_ready_st, 1'b1);
            if (hp_bck_st) break;
        end
        chk("first_rise_clocks", c, exp_rise);
    endtask

    initial begin
        int          acc, at;
        logic        ur;
        logic [31:0] st, mo;
        int          per;

        repeat (10) tick();
        chk("reset_ready", s_ready_st, 1'b0);
        chk("reset_din", hp_din_st, 1'b0);
        release_and_time_rise(20);

        // Stereo PAL frame
        push(16'h8001, 16'h7FFE, acc);
        s_valid = 1'b0;
        chk("push1_cycle", acc, 21);
        wait_strobe(at, ur);
        chk("first_load_clock", at, 1280);
        chk("first_load_underrun", ur, 1'b0);
        capture(st, mo, per);
        chk("frame_8001_st", st, 32'h8001_7FFE);
        chk("frame_8001_mo", mo, 32'hFFFF_FFFF);
        chk("pal_bit_period", per, 40);

        // Volume 1, then mute with empty buffer
        volume = 2'd1;
        push(16'h4000, 16'h2000, acc);
        s_valid = 1'b0;
        wait_strobe(at, ur);
        chk("vol_load_clock", at, 2560);
        chk("vol_underrun", ur, 1'b0);
        capture(st, mo, per);
        chk("vol1_st", st, 32'h1000_0800);
        chk("vol1_mo", mo, 32'h0C00_0C00);
        mute = 1'b1;
        wait_strobe(at, ur);
        chk("mute_underrun", ur, 1'b1);
        capture(st, mo, per);
        chk("mute_st", st, 32'h0000_0000);
        chk("mute_mo", mo, 32'h0000_0000);

        // Backpressure
        mute = 1'b0;
        volume = 2'd3;
        push(16'h1111, 16'h2222, acc);
        push(16'hA5A5, 16'h5A5A, acc);
        chk("ready_drops_when_full", s_ready_st, 1'b0);
        push(16'h1234, 16'h5678, acc);
        s_valid = 1'b0;
        chk("third_push_after_load", acc, 5121);
        wait_strobe(at, ur);
        chk("load_s2_underrun", ur, 1'b0);
        wait_strobe(at, ur);
        chk("load_s3_underrun", ur, 1'b0);

        // Underrun replays last sample
        wait_strobe(at, ur);
        chk("underrun_pulse", ur, 1'b1);
        chk("underrun_clock", at, 8960);
        capture(st, mo, per);
        chk("repeat_st", st, 32'h1234_5678);
        chk("repeat_mo", mo, 32'h3456_3456);

        // Push coinciding with the pop at load
        push(16'h0F0F, 16'hF0F0, acc);
        s_valid = 1'b0;
        for (int i = 0; i < 2000 && m_n != 11519; i++) tick();
        chk("align_load_minus_1", m_n, 11519);
        s_left = 16'h7FFF;
        s_right = 16'h0002;
        s_valid = 1'b1;
        chk("ready_before_simul", s_ready_st, 1'b1);
        tick();
        s_valid = 1'b0;
        chk("ready_after_simul", s_ready_st, 1'b1);
        wait_strobe(at, ur);
        chk("simul_next_underrun", ur, 1'b0);
        capture(st, mo, per);
        chk("simul_st", st, 32'h7FFF_0002);
        chk("simul_mo", mo, 32'h4000_4000);

        // Mid-run reset with buffered samples, then NTSC
        push(16'h0101, 16'h0202, acc);
        push(16'h0303, 16'h0404, acc);
        s_valid = 1'b0;
        repeat (300) tick();
        pll_lock = 1'b0;
        #1;
        chk("rst_st_bck", hp_bck_st, 1'b0);
        chk("rst_st_ws", hp_ws_st, 1'b0);
        chk("rst_st_din", hp_din_st, 1'b0);
        chk("rst_st_ready", s_ready_st, 1'b0);
        chk("rst_mo_bck", hp_bck_mo, 1'b0);
        chk("rst_mo_ready", s_ready_mo, 1'b0);
        ntscmode = 1'b1;
        repeat (5) tick();
        release_and_time_rise(21);
        wait_strobe(at, ur);
        chk("ntsc_first_load", at, 1344);
        chk("ntsc_fifo_flushed", ur, 1'b1);
        capture(st, mo, per);
        chk("ntsc_bit_period", per, 42);
        chk("ntsc_zero_frame", st, 32'h0000_0000);
        wait_strobe(at, ur);
        chk("ntsc_second_load", at, 2688);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

endmodule
